// File: rtl/strela_jm_pkg.sv
// Shared types and constants for the N-input join/merge node.
package strela_jm_pkg;

  typedef enum logic [1:0] {
    JM_JOIN       = 2'b00,
    JM_JOIN_CTRL  = 2'b01,
    JM_MERGE_RR   = 2'b10,
    JM_MERGE_PRIO = 2'b11
  } jm_mode_e;

  localparam int JM_MAX_IN = 8;

endpackage

// File: rtl/jm_skid_buffer.sv
// Two-entry registered output FIFO. Ready towards the producer comes only from
// the occupancy register, so the consumer's ready never reaches the producer combinationally.
module jm_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_v,
  output logic             push_r,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_v,
  input  logic             pop_r
);

  // Valid/ready: a beat moves on a rising edge where valid and ready are both 1;
  // the sender holds data and valid stable until then, and ready may depend on valid.
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push_r   = (count != 2'd2);
  assign pop_v    = (count != 2'd0);
  assign pop_data = head;
  assign push     = push_v & push_r;
  assign pop      = pop_v & pop_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count stays put: with one entry the new beat replaces the head,
          // otherwise the tail advances into the head.
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/join_merge_n.sv
// N-input join/merge node: all-lane join (optionally with control token) or
// single-lane merge with round-robin or fixed priority, feeding a 2-entry skid buffer.
module join_merge_n
  import strela_jm_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_IN     = 2,
  localparam int IDX_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  jm_mode_e                     mode,
  input  logic [NUM_IN*DATA_WIDTH-1:0] din,
  input  logic [NUM_IN-1:0]            din_v,
  output logic [NUM_IN-1:0]            din_r,
  input  logic                         cin,
  input  logic                         cin_v,
  output logic                         cin_r,
  output logic [NUM_IN*DATA_WIDTH-1:0] dout,
  output logic                         cout,
  output logic [IDX_W-1:0]             sel_idx,
  output logic                         dout_v,
  input  logic                         dout_r
);

  localparam int LW = NUM_IN * DATA_WIDTH;
  localparam int PW = LW + 1 + IDX_W;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] grant;
  logic [IDX_W:0]   idx;
  logic             found;
  logic             space;
  logic             fire;
  logic             is_merge;
  logic [LW-1:0]    push_dout;
  logic             push_cout;
  logic [IDX_W-1:0] push_sel;
  logic [PW-1:0]    pop_payload;

  assign is_merge = mode[1];

  // Rotate by the pointer, find the first valid lane, rotate back.
  always_comb begin
    base  = (mode == JM_MERGE_RR) ? ptr : '0;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = {1'b0, base} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_IN)) idx = idx - (IDX_W+1)'(NUM_IN);
      if (!found && din_v[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    case (mode)
      JM_JOIN:      fire = space & (&din_v);
      JM_JOIN_CTRL: fire = space & (&din_v) & cin_v;
      default:      fire = space & (|din_v);
    endcase
    fire  = fire & ~rst;
    din_r = is_merge ? ({{(NUM_IN-1){1'b0}}, fire} << grant) : {NUM_IN{fire}};
    cin_r = fire & (mode == JM_JOIN_CTRL);
  end

  always_comb begin
    push_dout = din;
    push_cout = cin;
    push_sel  = '0;
    if (is_merge) begin
      push_dout                 = '0;
      push_dout[DATA_WIDTH-1:0] = din[grant*DATA_WIDTH +: DATA_WIDTH];
      push_cout                 = (grant != '0);
      push_sel                  = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (fire && mode == JM_MERGE_RR) begin
      ptr <= (grant == IDX_W'(NUM_IN-1)) ? '0 : grant + 1'b1;
    end
  end

  jm_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push_data({push_sel, push_cout, push_dout}),
    .push_v   (fire),
    .push_r   (space),
    .pop_data (pop_payload),
    .pop_v    (dout_v),
    .pop_r    (dout_r)
  );

  assign dout    = pop_payload[LW-1:0];
  assign cout    = pop_payload[LW];
  assign sel_idx = pop_payload[PW-1 -: IDX_W];

endmodule

// File: tb/tb_join_merge_n.sv
// Bench for join_merge_n with four 16-bit lanes: scenario tasks plus an output scoreboard.
module tb_join_merge_n;
  import strela_jm_pkg::*;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int PW = N*DW + 1 + IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  jm_mode_e      mode = JM_JOIN;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0]  din_v = '0;
  logic [N-1:0]  din_r;
  logic          cin = 1'b0;
  logic          cin_v = 1'b0;
  logic          cin_r;
  logic [N*DW-1:0] dout;
  logic          cout;
  logic [IW-1:0] sel_idx;
  logic          dout_v;
  logic          dout_r = 1'b1;

  logic [PW-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  join_merge_n #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .din(din), .din_v(din_v), .din_r(din_r),
    .cin(cin), .cin_v(cin_v), .cin_r(cin_r),
    .dout(dout), .cout(cout), .sel_idx(sel_idx),
    .dout_v(dout_v), .dout_r(dout_r)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [N*DW-1:0] make_lanes(input logic [DW-1:0] b);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = b + DW'(i);
    return v;
  endfunction

  function automatic logic [PW-1:0] exp_join(input logic [N*DW-1:0] d, input logic c);
    return {IW'(0), c, d};
  endfunction

  function automatic logic [PW-1:0] exp_merge(input int g, input logic [DW-1:0] d);
    return {IW'(g), 1'(g != 0), {((N-1)*DW){1'b0}}, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic monitor_outputs();
    logic [PW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && dout_v && dout_r) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL out_unexpected: got %h, required no output", {sel_idx, cout, dout});
        end else begin
          e = exp_q.pop_front();
          if ({sel_idx, cout, dout} !== e) begin
            tests_failed++;
            $display("FAIL out_data: got %h, required %h", {sel_idx, cout, dout}, e);
          end
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mode = JM_JOIN; din = make_lanes(16'h0011); din_v = '1; dout_r = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (din_r !== 4'h0 || dout_v !== 1'b0 || cin_r !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ready: got din_r=%b cin_r=%b dout_v=%b, required 0 0 0", din_r, cin_r, dout_v);
      end
    end
    tests_run++;
    if ({sel_idx, cout, dout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required 0", {sel_idx, cout, dout});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (din_r !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_first_accept: got din_r=%b, required 1111", din_r);
    end
    exp_q.push_back(exp_join(din, cin));
    tick();
    din_v = '0;
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_out: got dout_v=%b, required 1", dout_v);
    end
    tick();
  endtask

  task automatic test_join();
    mode = JM_JOIN; din = make_lanes(16'h000A); cin = 1'b1; cin_v = 1'b0; din_v = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (din_r !== 4'h0) begin
        tests_failed++;
        $display("FAIL join_wait: got din_r=%b, required 0000", din_r);
      end
    end
    tick();
    din_v = 4'hF;
    @(negedge clk);
    tests_run++;
    if (din_r !== 4'hF || cin_r !== 1'b0) begin
      tests_failed++;
      $display("FAIL join_fire: got din_r=%b cin_r=%b, required 1111 0", din_r, cin_r);
    end
    exp_q.push_back(exp_join(din, 1'b1));
    tick();
    din_v = '0;
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1) begin
      tests_failed++;
      $display("FAIL join_latency: got dout_v=%b, required 1", dout_v);
    end
    tick();
  endtask

  task automatic test_join_ctrl();
    mode = JM_JOIN_CTRL; din = make_lanes(16'h0100); din_v = 4'hF; cin = 1'b0; cin_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (din_r !== 4'h0 || cin_r !== 1'b0) begin
        tests_failed++;
        $display("FAIL jctrl_wait: got din_r=%b cin_r=%b, required 0000 0", din_r, cin_r);
      end
    end
    tick();
    cin = 1'b1; cin_v = 1'b1;
    @(negedge clk);
    tests_run++;
    if (din_r !== 4'hF || cin_r !== 1'b1) begin
      tests_failed++;
      $display("FAIL jctrl_fire: got din_r=%b cin_r=%b, required 1111 1", din_r, cin_r);
    end
    exp_q.push_back(exp_join(din, 1'b1));
    tick();
    din_v = '0; cin_v = 1'b0; cin = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_merge_rr();
    int g;
    mode = JM_MERGE_RR; din = make_lanes(16'h1000); din_v = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g = k % N;
      tests_run++;
      if (din_r !== (4'b0001 << g)) begin
        tests_failed++;
        $display("FAIL rr_grant: beat %0d got din_r=%b, required lane %0d one-hot", k, din_r, g);
      end
      exp_q.push_back(exp_merge(g, din[g*DW +: DW]));
    end
    tick();
    din_v = '0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_merge_prio();
    mode = JM_MERGE_PRIO; din = make_lanes(16'h2000); din_v = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (din_r !== 4'b0010) begin
        tests_failed++;
        $display("FAIL prio_low: got din_r=%b, required 0010", din_r);
      end
      exp_q.push_back(exp_merge(1, din[1*DW +: DW]));
    end
    tick();
    din_v = 4'b1000;
    @(negedge clk);
    tests_run++;
    if (din_r !== 4'b1000) begin
      tests_failed++;
      $display("FAIL prio_next: got din_r=%b, required 1000", din_r);
    end
    exp_q.push_back(exp_merge(3, din[3*DW +: DW]));
    tick();
    din_v = '0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    int beat;
    int accepted;
    logic acc;
    logic [PW-1:0] first_exp;
    mode = JM_JOIN; cin = 1'b0; cin_v = 1'b0; beat = 0; accepted = 0;
    din = make_lanes(16'h4000); din_v = 4'hF; dout_r = 1'b0;
    first_exp = exp_join(make_lanes(16'h4000), 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = (din_r === 4'hF);
      if (dout_v) begin
        tests_run++;
        if ({sel_idx, cout, dout} !== first_exp) begin
          tests_failed++;
          $display("FAIL stall_hold: got %h, required %h", {sel_idx, cout, dout}, first_exp);
        end
      end
      if (acc) begin
        exp_q.push_back(exp_join(din, cin));
        accepted++;
      end
      tick();
      if (acc) begin
        beat++;
        din = make_lanes(DW'(16'h4000 + 16*beat));
      end
    end
    tests_run++;
    if (accepted != 2) begin
      tests_failed++;
      $display("FAIL stall_accept_count: got %0d, required 2", accepted);
    end
    @(negedge clk);
    tests_run++;
    if (din_r !== 4'h0) begin
      tests_failed++;
      $display("FAIL stall_full: got din_r=%b, required 0000", din_r);
    end
    tick();
    dout_r = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = (din_r === 4'hF);
      tests_run++;
      if (c == 0 && din_r !== 4'h0) begin
        tests_failed++;
        $display("FAIL release_first: got din_r=%b, required 0000", din_r);
      end else if (c != 0 && !acc) begin
        tests_failed++;
        $display("FAIL release_rate: cycle %0d got din_r=%b, required 1111", c, din_r);
      end
      if (acc) exp_q.push_back(exp_join(din, cin));
      tick();
      if (acc) begin
        beat++;
        din = make_lanes(DW'(16'h4000 + 16*beat));
      end
    end
    din_v = '0;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
    end
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: got dout_v=%b, required 0", dout_v);
    end
  endtask

  initial begin
    fork
      monitor_outputs();
      begin
        test_reset();
        test_join();
        test_join_ctrl();
        test_merge_rr();
        test_merge_prio();
        test_back_to_back();
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/join_merge_n.md
Name: join_merge_n

Overview:
- N-input join/merge node for the CGRA processing element. Generalises the 2-input join/merge to NUM_IN lanes.
- Adds two merge policies: round-robin merge (fair) and priority merge.
- Adds a registered 2-entry skid buffer on the output. This breaks the combinational ready/valid path between neighbouring PEs while keeping full throughput.

Parameters:
- DATA_WIDTH, 32, width of each data lane.
- NUM_IN, 2, number of input lanes; legal range 2..8.
- IDX_W (localparam), $clog2(NUM_IN), width of the selected-lane index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mode  in  2  quasi-static configuration (jm_mode_e).
- din  in  NUM_IN*DATA_WIDTH  input lanes, flat; lane i = din[i*DATA_WIDTH +: DATA_WIDTH].
- din_v  in  NUM_IN  per-lane valid.
- din_r  out  NUM_IN  per-lane ready.
- cin  in  1  control token.
- cin_v  in  1  control valid.
- cin_r  out  1  control ready.
- dout  out  NUM_IN*DATA_WIDTH  output lanes, flat.
- cout  out  1  output control bit.
- sel_idx  out  IDX_W  merge: granted lane index; join: 0.
- dout_v  out  1  output valid.
- dout_r  in  1  output ready.

Behaviour:
- Reset: buffer count=0, dout_v=0, dout=0, cout=0, sel_idx=0, RR pointer=0. din_r and cin_r are 0 while rst=1.
- Output stage: 2-entry FIFO (skid buffer). space = (count<2), taken from registered state only, so no combinational path from dout_r to din_r/cin_r.
- Latency: 1 cycle from the accepting edge to dout_v=1.
- Throughput: 1 transfer/cycle when dout_r=1.
- Push and pop in the same cycle leaves count unchanged.
- While dout_v=1 and dout_r=0, dout/cout/sel_idx must hold stable.
- Mode 00 JOIN:
  - fire = space & all din_v.
  - din_r[i] = fire for all i; cin_r = 0.
  - Pushed entry: dout = all lanes, cout = cin (unqualified), sel_idx = 0.
- Mode 01 JOIN_CTRL:
  - fire = space & all din_v & cin_v.
  - din_r[i] = fire; cin_r = fire.
  - Pushed entry: cout = cin.
- Mode 10 MERGE_RR:
  - fire = space & |din_v.
  - Grant g = first valid lane searching from ptr, ptr+1, ... with wrap mod NUM_IN.
  - Only din_r[g] = fire; other lanes are not consumed. cin_r = 0.
  - Pushed entry: lane 0 = din[g], other lanes = 0, sel_idx = g, cout = (g != 0).
  - On fire, ptr <= (g+1) mod NUM_IN; wrap from NUM_IN-1 to 0. Otherwise ptr holds.
- Mode 11 MERGE_PRIO: same as MERGE_RR except g = lowest-index valid lane, and ptr is not updated.
- No valid inputs, or buffer full: no fire, all din_r = 0, state holds.
- Mode changes only while idle (count=0, no din_v). Changing mode mid-operation is a configuration error. Entries already buffered are unaffected, and ptr is not cleared.
- Reset asserted mid-operation discards buffered entries; dout_v = 0 from the next cycle.
- Handshake rules:
  - Upstream must hold din/din_v until its ready is seen.
  - din_r may depend on din_v (join semantics). The skid buffer guarantees no ready-to-ready combinational path.

Decomposition:
- Package strela_jm_pkg:
  - typedef enum logic [1:0] jm_mode_e {JM_JOIN=2'b00, JM_JOIN_CTRL=2'b01, JM_MERGE_RR=2'b10, JM_MERGE_PRIO=2'b11}.
  - Constant JM_MAX_IN=8.
- Sub-module jm_skid_buffer (parametrised payload width, depth 2, valid/ready both sides).
- Arbitration (rotate, find-first, un-rotate) stays inline.

Test Plan:
- Reset: hold rst 3 cycles with all din_v=1 -> din_r=0, dout_v=0. First push completes the cycle after rst falls.
- JOIN, NUM_IN=4: lane 3 valid 2 cycles after lanes 0–2 -> no din_r until lane 3 is valid; then all din_r=1 for one cycle, dout_v=1 the next cycle with lanes {0xA,0xB,0xC,0xD}.
- JOIN_CTRL: lanes valid, cin_v=0 for 5 cycles -> no transfer. Then cin=1, cin_v=1 -> cin_r=din_r=1 together, and the output has cout=1.
- MERGE_RR, NUM_IN=4: all lanes valid continuously, dout_r=1 -> sel_idx sequence 0,1,2,3,0 (wraps). Each din_r is one-hot; lanes 1–3 of dout are 0.
- MERGE_PRIO: lanes 1 and 3 valid -> sel_idx=1, cout=1. Lane 3 is served only after lane 1 drops valid.
- Backpressure: dout_r=0 with a continuous stream -> exactly 2 entries accepted, then din_r=0. dout stays stable. Release dout_r -> entries drain in order with no loss or duplication, and full rate resumes.
